// File: rtl/counter_pkg.sv
// Shared constants and helpers for param_updown_counter and its prescaler.
package counter_pkg;

    // Direction encoding on the dir input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Ceiling log2. Returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Prescaler counter width. Never less than one bit.
    function automatic int prescale_width(input int prescale);
        return (clog2(prescale) < 1) ? 1 : clog2(prescale);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE and produces a one-cycle tick.
// With PRESCALE==1 the tick is just en, and no counter is built.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            // Every enabled cycle is a tick; clk, rst and clr are not needed here.
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, clr};
            assign tick = en;
        end else begin : g_divide
            localparam int CNT_W = prescale_width(PRESCALE);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

            logic [CNT_W-1:0] cnt;

            // Phase counter: cleared by reset or load, frozen while en is low.
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    cnt <= '0;
                end else if (en) begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end

            // Tick marks the enabled cycle on which the phase counter rolls over.
            assign tick = en && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down modulo counter with enable, clamped parallel load,
// clock prescaler, terminal-count and wrap flags.
// Build option: define PARAM_UPDOWN_COUNTER_SATURATE_EN to make the count
// saturate at 0 / MAX_COUNT instead of wrapping; wrap is then always 0.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 15,
    parameter int RESET_VAL = 0,
    parameter int PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
    // One extra bit so the clamp compare is never trivially constant when
    // MAX_COUNT is the all-ones value of WIDTH.
    localparam logic [WIDTH:0]   MAX_X = (WIDTH + 1)'(MAX_COUNT);

    logic             tick;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] step_q;
    logic             step_wrap;

    // Load clears the prescaler so a loaded value always gets a full period.
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (tick)
    );

    assign at_max  = (q == MAX_Q);
    assign at_zero = (q == '0);

    // Terminal count looks at the end the counter is currently heading for.
    assign tc = (dir == DIR_UP) ? at_max : at_zero;

    // Out-of-range load values are clamped to MAX_COUNT.
    always_comb begin
        load_q = load_val;
        if ({1'b0, load_val} > MAX_X) begin
            load_q = MAX_Q;
        end
    end

    // Next value for a counting step, and whether that step crosses the boundary.
    always_comb begin
        step_q    = q;
        step_wrap = 1'b0;
        if (dir == DIR_UP) begin
            if (at_max) begin
`ifdef PARAM_UPDOWN_COUNTER_SATURATE_EN
                step_q    = q;
`else
                step_q    = '0;
                step_wrap = 1'b1;
`endif
            end else begin
                step_q = q + 1'b1;
            end
        end else begin
            if (at_zero) begin
`ifdef PARAM_UPDOWN_COUNTER_SATURATE_EN
                step_q    = q;
`else
                step_q    = MAX_Q;
                step_wrap = 1'b1;
`endif
            end else begin
                step_q = q - 1'b1;
            end
        end
    end

    // Count register: reset beats load, load beats a step, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_Q;
        end else if (load) begin
            q <= load_q;
        end else if (en && tick) begin
            q <= step_q;
        end
    end

`ifdef PARAM_UPDOWN_COUNTER_SATURATE_EN
    // Saturating counts never wrap.
    logic unused_step_wrap;
    assign unused_step_wrap = step_wrap;
    assign wrap = 1'b0;
`else
    // Wrap pulse: high for exactly the cycle after a boundary-crossing step.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            wrap <= 1'b0;
        end else begin
            wrap <= en && tick && step_wrap;
        end
    end
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: default instance (a), a
// MAX_COUNT=9 / RESET_VAL=3 instance (b) and a PRESCALE=3 instance (c).
module tb_param_updown_counter;

`ifdef PARAM_UPDOWN_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_en, a_dir, a_load, a_tc, a_wrap;
    logic [3:0] a_lv, a_q;
    logic       b_rst, b_en, b_dir, b_load, b_tc, b_wrap;
    logic [3:0] b_lv, b_q;
    logic       c_rst, c_en, c_dir, c_load, c_tc, c_wrap;
    logic [3:0] c_lv, c_q;

    param_updown_counter dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .dir(a_dir), .load(a_load),
        .load_val(a_lv), .q(a_q), .tc(a_tc), .wrap(a_wrap)
    );

    param_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .RESET_VAL(3), .PRESCALE(1)) dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .dir(b_dir), .load(b_load),
        .load_val(b_lv), .q(b_q), .tc(b_tc), .wrap(b_wrap)
    );

    param_updown_counter #(.WIDTH(4), .MAX_COUNT(15), .RESET_VAL(0), .PRESCALE(3)) dut_c (
        .clk(clk), .rst(c_rst), .en(c_en), .dir(c_dir), .load(c_load),
        .load_val(c_lv), .q(c_q), .tc(c_tc), .wrap(c_wrap)
    );

    typedef struct {
        logic       rst, en, dir, load;
        logic [3:0] lv;
        logic [3:0] q;
        logic       tc, wrap;
    } vec_t;

    vec_t vecs[15];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(bit rst, bit en, bit dir, bit load, int lv, int q, bit tc, bit wrap);
        vec_t v;
        v.rst = rst; v.en = en; v.dir = dir; v.load = load;
        v.lv = 4'(lv); v.q = 4'(q); v.tc = tc; v.wrap = wrap;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Wait for the next active edge and step just past it before sampling.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Table: inputs applied before an edge, outputs expected just after it.
        vecs[0]  = mk(0, 1, 1, 1, 2,  2, 0, 0);                          // load beats step
        vecs[1]  = mk(0, 1, 0, 0, 0,  1, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0,  0, 1, 0);                          // tc at 0 going down
        vecs[3]  = SAT ? mk(0, 1, 0, 0, 0, 0, 1, 0) : mk(0, 1, 0, 0, 0, 15, 0, 1);
        vecs[4]  = SAT ? mk(0, 1, 0, 0, 0, 0, 1, 0) : mk(0, 1, 0, 0, 0, 14, 0, 0);
        vecs[5]  = SAT ? mk(0, 0, 0, 0, 0, 0, 1, 0) : mk(0, 0, 0, 0, 0, 14, 0, 0); // hold
        vecs[6]  = mk(0, 0, 1, 1, 9,  9, 0, 0);                          // plain load
        vecs[7]  = mk(0, 1, 1, 0, 0, 10, 0, 0);
        vecs[8]  = mk(0, 1, 1, 1, 15, 15, 1, 0);                         // load to max, no wrap
        vecs[9]  = SAT ? mk(0, 1, 1, 0, 0, 15, 1, 0) : mk(0, 1, 1, 0, 0, 0, 0, 1);
        vecs[10] = mk(0, 1, 1, 1, 15, 15, 1, 0);                         // load clears wrap
        vecs[11] = mk(0, 1, 0, 0, 0, 14, 0, 0);                          // immediate dir change
        vecs[12] = mk(1, 1, 1, 1, 5,  0, 0, 0);                          // reset beats load
        vecs[13] = SAT ? mk(0, 1, 0, 0, 0, 0, 1, 0) : mk(0, 1, 0, 0, 0, 15, 0, 1);
        vecs[14] = mk(1, 1, 1, 0, 0,  0, 0, 0);                          // reset clears wrap

        a_rst = 1; a_en = 0; a_dir = 1; a_load = 0; a_lv = 0;
        b_rst = 1; b_en = 0; b_dir = 1; b_load = 0; b_lv = 0;
        c_rst = 1; c_en = 0; c_dir = 1; c_load = 0; c_lv = 0;

        // Reset state of all instances.
        cyc();
        chk("a_reset_q", a_q, 0);
        chk("a_reset_tc", a_tc, 0);
        chk("a_reset_wrap", a_wrap, 0);
        chk("b_reset_q", b_q, 3);
        chk("c_reset_q", c_q, 0);
        #1;
        a_rst = 0; a_en = 1; a_dir = 1;

        // Full up-count through the wrap.
        for (int i = 1; i <= 17; i++) begin
            int eq;
            cyc();
            eq = SAT ? ((i > 15) ? 15 : i) : (i % 16);
            chk($sformatf("up%0d_q", i), a_q, eq);
            chk($sformatf("up%0d_tc", i), a_tc, (eq == 15) ? 1 : 0);
            chk($sformatf("up%0d_wrap", i), a_wrap, (!SAT && i == 16) ? 1 : 0);
        end

        // Table-driven vectors on instance a.
        for (int i = 0; i < 15; i++) begin
            a_rst = vecs[i].rst; a_en = vecs[i].en; a_dir = vecs[i].dir;
            a_load = vecs[i].load; a_lv = vecs[i].lv;
            cyc();
            chk($sformatf("vec%0d_q", i), a_q, vecs[i].q);
            chk($sformatf("vec%0d_tc", i), a_tc, vecs[i].tc);
            chk($sformatf("vec%0d_wrap", i), a_wrap, vecs[i].wrap);
        end

        // tc follows dir combinationally at q=0.
        a_rst = 0; a_en = 0; a_load = 0; a_dir = 0;
        #1;
        chk("tc_dir_down_at_0", a_tc, 1);
        a_dir = 1;
        #1;
        chk("tc_dir_up_at_0", a_tc, 0);

`ifdef PARAM_UPDOWN_COUNTER_SATURATE_EN
        // Saturation at the top, then back down.
        a_load = 1; a_lv = 14; a_en = 0; a_dir = 1;
        cyc();
        chk("sat_load_q", a_q, 14);
        a_load = 0; a_en = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("sat%0d_q", i), a_q, 15);
            chk($sformatf("sat%0d_wrap", i), a_wrap, 0);
            chk($sformatf("sat%0d_tc", i), a_tc, 1);
        end
        a_dir = 0;
        cyc();
        chk("sat_down_q", a_q, 14);
`endif

        // Instance b: clamp on load, wrap at MAX_COUNT=9.
        b_rst = 0; b_load = 1; b_lv = 13; b_en = 0; b_dir = 1;
        cyc();
        chk("b_clamp_q", b_q, 9);
        chk("b_clamp_tc", b_tc, 1);
        chk("b_clamp_wrap", b_wrap, 0);
        b_load = 0; b_en = 1;
        cyc();
        chk("b_wrap9_q", b_q, SAT ? 9 : 0);
        chk("b_wrap9_wrap", b_wrap, SAT ? 0 : 1);
        cyc();
        chk("b_after_q", b_q, SAT ? 9 : 1);
        chk("b_after_wrap", b_wrap, 0);
        b_load = 1; b_lv = 7; b_dir = 0;
        cyc();
        chk("b_load7_q", b_q, 7);
        b_load = 0; b_lv = 0; b_en = 0;
        b_dir = 1; b_load = 1; b_lv = 9;
        cyc();
        chk("b_load9_q", b_q, 9);

        // Instance c: PRESCALE=3 stepping and phase preservation.
        c_rst = 0; c_en = 1; c_dir = 1;
        begin
            int exp_q[7] = '{0, 0, 1, 1, 1, 2, 2};
            for (int i = 0; i < 7; i++) begin
                cyc();
                chk($sformatf("c_pre%0d_q", i), c_q, exp_q[i]);
            end
        end
        c_en = 0;
        cyc();
        chk("c_freeze0_q", c_q, 2);
        cyc();
        chk("c_freeze1_q", c_q, 2);
        c_en = 1;
        cyc();
        chk("c_resume0_q", c_q, 2);
        cyc();
        chk("c_resume1_q", c_q, 3);

        // Load clears the prescaler; then reset mid-prescale at q=11.
        c_load = 1; c_lv = 10;
        cyc();
        chk("c_load_q", c_q, 10);
        c_load = 0;
        cyc(); cyc();
        chk("c_hold10_q", c_q, 10);
        cyc();
        chk("c_step11_q", c_q, 11);
        cyc();
        chk("c_mid_q", c_q, 11);
        c_rst = 1;
        cyc();
        chk("c_rst_q", c_q, 0);
        chk("c_rst_wrap", c_wrap, 0);
        c_rst = 0;
        cyc();
        chk("c_restart0_q", c_q, 0);
        cyc();
        chk("c_restart1_q", c_q, 0);
        cyc();
        chk("c_restart2_q", c_q, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
